conversor_display: RTL and testbench

Downstream stage of the synchronous calculator: captures the 8-bit unsigned result on its output bus on request, converts it to three BCD digits with a sequential shift-and-add-3 (double-dabble) engine, and drives a multiplexed 3-digit common-anode 7-segment display with leading-zero blanking. Conversion and display refresh run concurrently. The previously converted value stays on the display until a new conversion completes.

---
 rtl/calc_pkg.sv | 44 ++++
 rtl/decodificador_7seg.sv | 38 +++
 rtl/conversor_display.sv | 173 +++++++++++++++++
 tb/tb_conversor_display.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator display stage:
//   - estado_t     : conversion FSM states (OCIOSO, CONVERTE)
//   - N_ITER       : number of double-dabble iterations for an 8-bit value
//   - SEG_*        : active-low 7-segment patterns {g,f,e,d,c,b,a}
//   - AN_*         : active-low one-hot anode enables
//   - ajusta_bcd() : the "add 3 when >= 5" correction applied to one BCD nibble
// ---------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic {
    OCIOSO   = 1'b0,
    CONVERTE = 1'b1
  } estado_t;

  localparam int N_ITER = 8;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] AN_UNIDADE = 3'b110;
  localparam logic [2:0] AN_DEZENA  = 3'b101;
  localparam logic [2:0] AN_CENTENA = 3'b011;

  // A nibble that is 5 or more would overflow past 9 once doubled by the
  // following shift, so it is pre-corrected by adding 3.
  function automatic logic [3:0] ajusta_bcd(input logic [3:0] nibble);
    if (nibble >= 4'd5) begin
      return nibble + 4'd3;
    end
    return nibble;
  endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// ---------------------------------------------------------------------------
// decodificador_7seg
// Combinational BCD to 7-segment decoder for a common-anode display.
// Ports:
//   i_bcd        in  4  BCD digit to show (10..15 are shown blank)
//   i_apagar     in  1  force the digit blank (leading-zero suppression)
//   o_segmentos  out 7  {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module decodificador_7seg
  import calc_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_apagar,
  output logic [6:0] o_segmentos
);

  // Blank is the default so that both the suppression request and any
  // non-decimal nibble leave every segment dark.
  always_comb begin
    o_segmentos = SEG_BLANK;
    if (!i_apagar) begin
      case (i_bcd)
        4'd0:    o_segmentos = SEG_0;
        4'd1:    o_segmentos = SEG_1;
        4'd2:    o_segmentos = SEG_2;
        4'd3:    o_segmentos = SEG_3;
        4'd4:    o_segmentos = SEG_4;
        4'd5:    o_segmentos = SEG_5;
        4'd6:    o_segmentos = SEG_6;
        4'd7:    o_segmentos = SEG_7;
        4'd8:    o_segmentos = SEG_8;
        4'd9:    o_segmentos = SEG_9;
        default: o_segmentos = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/conversor_display.sv
// ---------------------------------------------------------------------------
// conversor_display
// Captures the 8-bit calculator result, converts it to three BCD digits with
// a sequential shift-and-add-3 engine, and scans a 3-digit common-anode
// 7-segment display with leading-zero blanking. Conversion and scanning run
// independently; the display keeps the last finished result.
// Parameters:
//   DIV_REFRESH  clock cycles each digit stays lit (>= 1)
// Ports:
//   clk        in  1  system clock, rising edge
//   rst_n      in  1  synchronous active-low reset
//   valor      in  8  unsigned value to convert
//   carregar   in  1  capture request, honoured only while idle
//   ocupado    out 1  conversion in progress
//   pronto     out 1  one-cycle pulse when new digits are valid
//   centena    out 4  hundreds BCD digit
//   dezena     out 4  tens BCD digit
//   unidade    out 4  units BCD digit
//   anodos     out 3  active-low one-hot digit enables (bit 0 = units)
//   segmentos  out 7  {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module conversor_display
  import calc_pkg::*;
#(
  parameter int DIV_REFRESH = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] valor,
  input  logic       carregar,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] centena,
  output logic [3:0] dezena,
  output logic [3:0] unidade,
  output logic [2:0] anodos,
  output logic [6:0] segmentos
);

  localparam int             CNT_W     = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_REFRESH - 1);
  localparam logic [2:0]     ITER_LAST = 3'(N_ITER - 1);

  estado_t          r_estado;
  logic [19:0]      r_shift;
  logic [2:0]       r_iter;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;

  logic [19:0]      w_ajustado;
  logic [19:0]      w_deslocado;
  logic [3:0]       w_digito;
  logic             w_apagar;
  logic [2:0]       w_anodo;
  logic [6:0]       w_segmentos;

  // One double-dabble step: correct the three BCD nibbles, then shift the
  // whole register left. The binary part is untouched by the correction.
  always_comb begin
    w_ajustado  = {ajusta_bcd(r_shift[19:16]),
                   ajusta_bcd(r_shift[15:12]),
                   ajusta_bcd(r_shift[11:8]),
                   r_shift[7:0]};
    w_deslocado = w_ajustado << 1;
  end

  // Conversion FSM. The digit registers are written from the result of the
  // final step directly, so they become valid on the same edge that ends the
  // conversion and raises pronto. A request while converting is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado <= OCIOSO;
      r_shift  <= '0;
      r_iter   <= '0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
      centena  <= '0;
      dezena   <= '0;
      unidade  <= '0;
    end else begin
      pronto <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (carregar) begin
            r_shift  <= {12'b0, valor};
            r_iter   <= '0;
            ocupado  <= 1'b1;
            r_estado <= CONVERTE;
          end
        end
        CONVERTE: begin
          r_shift <= w_deslocado;
          r_iter  <= r_iter + 3'd1;
          if (r_iter == ITER_LAST) begin
            centena  <= w_deslocado[19:16];
            dezena   <= w_deslocado[15:12];
            unidade  <= w_deslocado[11:8];
            pronto   <= 1'b1;
            ocupado  <= 1'b0;
            r_estado <= OCIOSO;
          end
        end
        default: begin
          r_estado <= OCIOSO;
          ocupado  <= 1'b0;
        end
      endcase
    end
  end

  // Refresh timer and scan index. The index walks units, tens, hundreds and
  // is never disturbed by a finished conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Digit mux with leading-zero suppression: hundreds hide when zero, tens
  // hide only when hundreds are also zero, units always show.
  always_comb begin
    w_digito = unidade;
    w_apagar = 1'b0;
    w_anodo  = AN_UNIDADE;
    case (r_idx)
      2'd0: begin
        w_digito = unidade;
        w_apagar = 1'b0;
        w_anodo  = AN_UNIDADE;
      end
      2'd1: begin
        w_digito = dezena;
        w_apagar = (centena == 4'd0) && (dezena == 4'd0);
        w_anodo  = AN_DEZENA;
      end
      2'd2: begin
        w_digito = centena;
        w_apagar = (centena == 4'd0);
        w_anodo  = AN_CENTENA;
      end
      default: begin
        w_digito = unidade;
        w_apagar = 1'b0;
        w_anodo  = AN_UNIDADE;
      end
    endcase
  end

  decodificador_7seg u_decodificador (
    .i_bcd       (w_digito),
    .i_apagar    (w_apagar),
    .o_segmentos (w_segmentos)
  );

  // Anode and segment pins are registered together so a digit change never
  // shows the old pattern on the new anode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anodos    <= AN_UNIDADE;
      segmentos <= SEG_0;
    end else begin
      anodos    <= w_anodo;
      segmentos <= w_segmentos;
    end
  end

endmodule

// File: tb/tb_conversor_display.sv
// ---------------------------------------------------------------------------
// tb_conversor_display
// Directed self-checking bench for conversor_display with DIV_REFRESH = 4.
// ---------------------------------------------------------------------------
module tb_conversor_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] valor = 8'd0;
  logic       carregar = 1'b0;
  logic       ocupado;
  logic       pronto;
  logic [3:0] centena;
  logic [3:0] dezena;
  logic [3:0] unidade;
  logic [2:0] anodos;
  logic [6:0] segmentos;

  int total = 0;
  int bad   = 0;

  conversor_display #(.DIV_REFRESH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valor     (valor),
    .carregar  (carregar),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .centena   (centena),
    .dezena    (dezena),
    .unidade   (unidade),
    .anodos    (anodos),
    .segmentos (segmentos)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle away from it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise carregar for the capture edge E0.
  task automatic applyStimulus(input logic [7:0] v);
    valor    = v;
    carregar = 1'b1;
    tick();
    carregar = 1'b0;
    checkOutput("ocupado_e0", ocupado, 1);
    checkOutput("pronto_e0", pronto, 0);
  endtask

  // From edge fromEdge (already sampled) run up to E8 and check the result.
  task automatic runRest(input int fromEdge, input bit toggle,
                         input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
    for (int e = fromEdge + 1; e <= 8; e++) begin
      if (toggle) valor = ~valor;
      tick();
      if (e < 8) begin
        checkOutput("ocupado_mid", ocupado, 1);
        checkOutput("pronto_mid", pronto, 0);
      end
    end
    checkOutput("ocupado_e8", ocupado, 0);
    checkOutput("pronto_e8", pronto, 1);
    checkOutput("centena", centena, c);
    checkOutput("dezena", dezena, d);
    checkOutput("unidade", unidade, u);
  endtask

  // Edge E9: the pulse is gone and nothing new started.
  task automatic afterDone;
    tick();
    checkOutput("pronto_e9", pronto, 0);
    checkOutput("ocupado_e9", ocupado, 0);
  endtask

  // Watch one full scan and check each lit digit's pattern.
  task automatic checkScan(input logic [6:0] segH, input logic [6:0] segT, input logic [6:0] segU);
    logic [2:0] seen;
    seen = 3'b000;
    for (int i = 0; i < 12; i++) begin
      tick();
      case (anodos)
        3'b110: begin seen[0] = 1'b1; checkOutput("seg_unidade", segmentos, segU); end
        3'b101: begin seen[1] = 1'b1; checkOutput("seg_dezena", segmentos, segT); end
        3'b011: begin seen[2] = 1'b1; checkOutput("seg_centena", segmentos, segH); end
        default: checkOutput("anodos_legal", anodos, 3'b110);
      endcase
    end
    checkOutput("scan_all_digits", seen, 3'b111);
  endtask

  initial begin
    int idx;
    logic [2:0] expAn;
    logic [6:0] expSeg;

    // Reset and idle scan.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("rst_ocupado", ocupado, 0);
    checkOutput("rst_pronto", pronto, 0);
    checkOutput("rst_centena", centena, 0);
    checkOutput("rst_dezena", dezena, 0);
    checkOutput("rst_unidade", unidade, 0);
    checkOutput("rst_anodos", anodos, 3'b110);
    checkOutput("rst_segmentos", segmentos, 7'b1000000);
    for (int k = 1; k <= 13; k++) begin
      tick();
      idx = ((k - 1) / 4) % 3;
      expAn  = (idx == 0) ? 3'b110 : (idx == 1) ? 3'b101 : 3'b011;
      expSeg = (idx == 0) ? 7'b1000000 : 7'b1111111;
      checkOutput("idle_anodos", anodos, expAn);
      checkOutput("idle_segmentos", segmentos, expSeg);
    end

    // 255 -> 2,5,5
    applyStimulus(8'd255);
    runRest(0, 1'b0, 4'd2, 4'd5, 4'd5);
    afterDone();
    checkScan(7'b0100100, 7'b0010010, 7'b0010010);

    // 7 -> 0,0,7 with hundreds and tens blank
    applyStimulus(8'd7);
    runRest(0, 1'b0, 4'd0, 4'd0, 4'd7);
    afterDone();
    checkScan(7'b1111111, 7'b1111111, 7'b1111000);

    // 100 with a request for 42 at E3: ignored, not queued
    applyStimulus(8'd100);
    tick();
    tick();
    valor    = 8'd42;
    carregar = 1'b1;
    tick();
    carregar = 1'b0;
    checkOutput("ocupado_e3", ocupado, 1);
    runRest(3, 1'b0, 4'd1, 4'd0, 4'd0);
    afterDone();
    checkScan(7'b1111001, 7'b1000000, 7'b1000000);

    // Back-to-back: 100 then 42 accepted at E9
    applyStimulus(8'd100);
    runRest(0, 1'b0, 4'd1, 4'd0, 4'd0);
    valor    = 8'd42;
    carregar = 1'b1;
    tick();
    carregar = 1'b0;
    checkOutput("b2b_pronto_e9", pronto, 0);
    checkOutput("b2b_ocupado_e9", ocupado, 1);
    runRest(0, 1'b0, 4'd0, 4'd4, 4'd2);
    afterDone();
    checkScan(7'b1111111, 7'b0011001, 7'b0100100);

    // 200 with valor toggling during conversion
    applyStimulus(8'd200);
    runRest(0, 1'b1, 4'd2, 4'd0, 4'd0);
    afterDone();
    checkScan(7'b0100100, 7'b1000000, 7'b1000000);

    // Reset at E4 aborts the conversion
    applyStimulus(8'd123);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("abort_ocupado", ocupado, 0);
    checkOutput("abort_pronto", pronto, 0);
    checkOutput("abort_centena", centena, 0);
    checkOutput("abort_dezena", dezena, 0);
    checkOutput("abort_unidade", unidade, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput("abort_no_pronto", pronto, 0);
    end
    applyStimulus(8'd9);
    runRest(0, 1'b0, 4'd0, 4'd0, 4'd9);
    afterDone();
    checkScan(7'b1111111, 7'b1111111, 7'b0010000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
